// File: rtl/regwrite_scoreboard.sv
// rtl/regwrite_scoreboard.sv - one-hot register write-enable generator with pending-write scoreboard
module regwrite_scoreboard #(
  parameter int REG_COUNT         = 16,
  parameter int ADDR_W            = 4,
  parameter int ZERO_REG_READONLY = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  input  logic [ADDR_W-1:0]              issue_rdest,
  input  logic [ADDR_W-1:0]              issue_src_a,
  input  logic [ADDR_W-1:0]              issue_src_b,
  output logic                           issue_ready,
  input  logic                           wb_valid,
  input  logic [ADDR_W-1:0]              wb_rdest,
  output logic [REG_COUNT-1:0]           reg_enable,
  output logic [REG_COUNT-1:0]           busy,
  output logic [$clog2(REG_COUNT+1)-1:0] pending_count,
  output logic                           wb_error
);

  localparam int CNT_W = $clog2(REG_COUNT+1);

  // Addresses beyond the file, or register 0 when it is hardwired, decode to all zeros,
  // so they can never set/clear busy, pulse an enable or raise a hazard.
  function automatic logic [REG_COUNT-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [REG_COUNT-1:0] onehot;
    onehot = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (addr == ADDR_W'(i) && !(ZERO_REG_READONLY != 0 && i == 0)) begin
        onehot[i] = 1'b1;
      end
    end
    return onehot;
  endfunction

  logic [REG_COUNT-1:0] dec_rdest;
  logic [REG_COUNT-1:0] dec_src_a;
  logic [REG_COUNT-1:0] dec_src_b;
  logic [REG_COUNT-1:0] dec_wb;
  logic [REG_COUNT-1:0] set_vec;
  logic [REG_COUNT-1:0] clr_vec;
  logic [REG_COUNT-1:0] busy_next;
  logic                 cnt_up;
  logic                 cnt_down;

  assign dec_rdest = decode(issue_rdest);
  assign dec_src_a = decode(issue_src_a);
  assign dec_src_b = decode(issue_src_b);
  assign dec_wb    = decode(wb_rdest);

  // Stall looks only at registered busy bits: a writeback in the same cycle does not bypass.
  assign issue_ready = ~|(busy & (dec_rdest | dec_src_a | dec_src_b));

  assign set_vec   = (issue_valid && issue_ready) ? dec_rdest : '0;
  assign clr_vec   = wb_valid ? dec_wb : '0;

  // Set is applied after clear so a same-register issue/writeback leaves the bit busy.
  assign busy_next = (busy & ~clr_vec) | set_vec;

  // At most one bit rises and one bit falls per cycle, so the counter moves by -1..+1.
  assign cnt_up    = |(busy_next & ~busy);
  assign cnt_down  = |(busy & ~busy_next);

  // Scoreboard bits, write-enable pulse, pending counter and sticky writeback error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy          <= '0;
      reg_enable    <= '0;
      pending_count <= '0;
      wb_error      <= 1'b0;
    end else begin
      busy       <= busy_next;
      reg_enable <= clr_vec;
      if (cnt_up && !cnt_down) begin
        pending_count <= pending_count + CNT_W'(1);
      end else if (cnt_down && !cnt_up) begin
        pending_count <= pending_count - CNT_W'(1);
      end
      if (|(clr_vec & ~busy)) begin
        wb_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regwrite_scoreboard.sv
// tb/tb_regwrite_scoreboard.sv - self-checking bench for regwrite_scoreboard
module tb_regwrite_scoreboard;

  localparam int RC  = 16;
  localparam int ZRC = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_rdest, issue_src_a, issue_src_b;
  logic        issue_ready;
  logic        wb_valid;
  logic [3:0]  wb_rdest;
  logic [15:0] reg_enable, busy;
  logic [4:0]  pending_count;
  logic        wb_error;

  logic        z_issue_valid;
  logic [3:0]  z_issue_rdest, z_issue_src_a, z_issue_src_b;
  logic        z_issue_ready;
  logic        z_wb_valid;
  logic [3:0]  z_wb_rdest;
  logic [11:0] z_reg_enable, z_busy;
  logic [3:0]  z_pending_count;
  logic        z_wb_error;

  regwrite_scoreboard #(.REG_COUNT(RC), .ADDR_W(4), .ZERO_REG_READONLY(0)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rdest(issue_rdest),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rdest(wb_rdest),
    .reg_enable(reg_enable), .busy(busy), .pending_count(pending_count), .wb_error(wb_error)
  );

  regwrite_scoreboard #(.REG_COUNT(ZRC), .ADDR_W(4), .ZERO_REG_READONLY(1)) dut_z (
    .clk(clk), .reset(reset),
    .issue_valid(z_issue_valid), .issue_rdest(z_issue_rdest),
    .issue_src_a(z_issue_src_a), .issue_src_b(z_issue_src_b), .issue_ready(z_issue_ready),
    .wb_valid(z_wb_valid), .wb_rdest(z_wb_rdest),
    .reg_enable(z_reg_enable), .busy(z_busy), .pending_count(z_pending_count), .wb_error(z_wb_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a set of pending registers, a sticky flag, the last writeback index
  bit m_busy[RC];
  bit m_err;
  int m_en_idx;
  bit exp_ready;
  logic obs_ready;

  function automatic void model_clear();
    for (int i = 0; i < RC; i++) m_busy[i] = 1'b0;
    m_err    = 1'b0;
    m_en_idx = -1;
  endfunction

  function automatic logic [15:0] exp_busy();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < RC; i++) if (m_busy[i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int exp_count();
    int n;
    n = 0;
    for (int i = 0; i < RC; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [15:0] exp_en();
    logic [15:0] v;
    v = '0;
    if (m_en_idx >= 0) v[m_en_idx] = 1'b1;
    return v;
  endfunction

  function automatic bit pend(input int a);
    return (a < RC) ? m_busy[a] : 1'b0;
  endfunction

  task automatic idle_inputs();
    issue_valid = 0; issue_rdest = 0; issue_src_a = 0; issue_src_b = 0;
    wb_valid = 0; wb_rdest = 0;
    z_issue_valid = 0; z_issue_rdest = 0; z_issue_src_a = 0; z_issue_src_b = 0;
    z_wb_valid = 0; z_wb_rdest = 0;
  endtask

  // Drive one cycle on the main DUT from a negedge, advance the model, return at the next negedge
  task automatic cycle(input bit iv, input int rd, input int sa, input int sb,
                       input bit wv, input int wr);
    issue_valid = iv; issue_rdest = 4'(rd); issue_src_a = 4'(sa); issue_src_b = 4'(sb);
    wb_valid = wv; wb_rdest = 4'(wr);
    #1;
    exp_ready = !(pend(rd) || pend(sa) || pend(sb));
    obs_ready = issue_ready;
    @(posedge clk);
    m_en_idx = -1;
    if (wv && wr < RC) begin
      m_en_idx = wr;
      if (!m_busy[wr]) m_err = 1'b1;
      m_busy[wr] = 1'b0;
    end
    if (iv && exp_ready && rd < RC) m_busy[rd] = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    n_tests++; if (busy !== 16'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0000", busy); end
    n_tests++; if (reg_enable !== 16'h0) begin n_fail++; $display("FAIL reset_en: got %h want 0000", reg_enable); end
    n_tests++; if (pending_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", pending_count); end
    n_tests++; if (wb_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", wb_error); end
    n_tests++; if (z_busy !== 12'h0 || z_reg_enable !== 12'h0 || z_wb_error !== 1'b0 || z_pending_count !== 4'd0)
      begin n_fail++; $display("FAIL reset_z: busy %h en %h err %b cnt %0d want all 0", z_busy, z_reg_enable, z_wb_error, z_pending_count); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_wb_not_busy();
    apply_reset();
    cycle(0, 0, 0, 0, 1, 5);
    n_tests++; if (reg_enable !== 16'h0020) begin n_fail++; $display("FAIL wb5_en: got %h want 0020", reg_enable); end
    n_tests++; if (wb_error !== 1'b1) begin n_fail++; $display("FAIL wb5_err: got %b want 1", wb_error); end
    n_tests++; if (pending_count !== 5'd0) begin n_fail++; $display("FAIL wb5_count: got %0d want 0", pending_count); end
    cycle(0, 0, 0, 0, 0, 0);
    n_tests++; if (reg_enable !== 16'h0) begin n_fail++; $display("FAIL wb5_en_drop: got %h want 0000", reg_enable); end
    n_tests++; if (wb_error !== 1'b1) begin n_fail++; $display("FAIL wb5_err_sticky: got %b want 1", wb_error); end
  endtask

  task automatic test_raw();
    apply_reset();
    cycle(1, 3, 0, 0, 0, 0);
    n_tests++; if (busy !== 16'h0008 || pending_count !== 5'd1)
      begin n_fail++; $display("FAIL raw_set: busy %h cnt %0d want 0008/1", busy, pending_count); end
    for (int k = 0; k < 2; k++) begin
      cycle(1, 10, 3, 0, 0, 0);
      n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b want 0", obs_ready); end
    end
    cycle(1, 10, 3, 0, 1, 3);
    n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass: got %b want 0", obs_ready); end
    n_tests++; if (busy !== 16'h0 || pending_count !== 5'd0 || reg_enable !== 16'h0008 || wb_error !== 1'b0)
      begin n_fail++; $display("FAIL raw_wb: busy %h cnt %0d en %h err %b want 0000/0/0008/0", busy, pending_count, reg_enable, wb_error); end
    cycle(1, 10, 3, 0, 0, 0);
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", obs_ready); end
    n_tests++; if (busy !== 16'h0400 || reg_enable !== 16'h0)
      begin n_fail++; $display("FAIL raw_after: busy %h en %h want 0400/0000", busy, reg_enable); end
  endtask

  task automatic test_same_edge();
    apply_reset();
    cycle(1, 7, 0, 0, 0, 0);
    // WAW against pending r7 stalls, the writeback still lands
    cycle(1, 7, 0, 0, 1, 7);
    n_tests++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL same_waw_stall: got %b want 0", obs_ready); end
    n_tests++; if (busy !== 16'h0 || reg_enable !== 16'h0080 || pending_count !== 5'd0 || wb_error !== 1'b0)
      begin n_fail++; $display("FAIL same_wb: busy %h en %h cnt %0d err %b want 0000/0080/0/0", busy, reg_enable, pending_count, wb_error); end
    // Accepted issue and writeback to r7 at one edge: set wins
    cycle(1, 7, 0, 0, 1, 7);
    n_tests++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL same_accept: got %b want 1", obs_ready); end
    n_tests++; if (busy !== 16'h0080 || reg_enable !== 16'h0080 || pending_count !== 5'd1)
      begin n_fail++; $display("FAIL same_setwins: busy %h en %h cnt %0d want 0080/0080/1", busy, reg_enable, pending_count); end
    // Issue r2 while writing back busy r7: both take effect, count net zero
    cycle(1, 2, 0, 0, 1, 7);
    n_tests++; if (busy !== 16'h0004 || reg_enable !== 16'h0080 || pending_count !== 5'd1)
      begin n_fail++; $display("FAIL same_diff: busy %h en %h cnt %0d want 0004/0080/1", busy, reg_enable, pending_count); end
  endtask

  task automatic test_back_to_back_and_async_reset();
    apply_reset();
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0);
    cycle(1, 4, 0, 0, 0, 0);
    cycle(1, 9, 0, 0, 0, 0);
    n_tests++; if (busy !== 16'h0216 || pending_count !== 5'd4)
      begin n_fail++; $display("FAIL b2b_issue: busy %h cnt %0d want 0216/4", busy, pending_count); end
    cycle(0, 0, 0, 0, 1, 2);
    n_tests++; if (reg_enable !== 16'h0004) begin n_fail++; $display("FAIL b2b_wb1: got %h want 0004", reg_enable); end
    cycle(1, 5, 1, 0, 1, 4);
    n_tests++; if (reg_enable !== 16'h0010) begin n_fail++; $display("FAIL b2b_wb2: got %h want 0010", reg_enable); end
    // Reset between edges while an enable pulse is live
    issue_valid = 1; issue_rdest = 4'd9; issue_src_a = 4'd1;
    #2;
    reset = 1'b1;
    #1;
    n_tests++; if (busy !== 16'h0 || reg_enable !== 16'h0 || pending_count !== 5'd0 || wb_error !== 1'b0 || issue_ready !== 1'b1)
      begin n_fail++; $display("FAIL async_reset: busy %h en %h cnt %0d err %b rdy %b want 0/0/0/0/1", busy, reg_enable, pending_count, wb_error, issue_ready); end
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_zero_reg();
    apply_reset();
    z_issue_valid = 1; z_issue_rdest = 0; z_issue_src_a = 0; z_issue_src_b = 0;
    #1;
    n_tests++; if (z_issue_ready !== 1'b1) begin n_fail++; $display("FAIL z_r0_ready: got %b want 1", z_issue_ready); end
    @(negedge clk);
    n_tests++; if (z_busy !== 12'h0 || z_pending_count !== 4'd0)
      begin n_fail++; $display("FAIL z_r0_busy: busy %h cnt %0d want 000/0", z_busy, z_pending_count); end
    z_issue_valid = 0; z_wb_valid = 1; z_wb_rdest = 0;
    @(negedge clk);
    n_tests++; if (z_reg_enable !== 12'h0 || z_wb_error !== 1'b0)
      begin n_fail++; $display("FAIL z_wb0: en %h err %b want 000/0", z_reg_enable, z_wb_error); end
    z_wb_rdest = 14;
    @(negedge clk);
    n_tests++; if (z_reg_enable !== 12'h0 || z_wb_error !== 1'b0)
      begin n_fail++; $display("FAIL z_wb14: en %h err %b want 000/0", z_reg_enable, z_wb_error); end
    z_issue_valid = 1; z_issue_rdest = 5; z_wb_rdest = 11;
    @(negedge clk);
    n_tests++; if (z_busy !== 12'h020 || z_reg_enable !== 12'h800 || z_wb_error !== 1'b1 || z_pending_count !== 4'd1)
      begin n_fail++; $display("FAIL z_top: busy %h en %h err %b cnt %0d want 020/800/1/1", z_busy, z_reg_enable, z_wb_error, z_pending_count); end
    z_wb_valid = 0; z_issue_rdest = 13; z_issue_src_a = 5;
    #1;
    n_tests++; if (z_issue_ready !== 1'b0) begin n_fail++; $display("FAIL z_hazard: got %b want 0", z_issue_ready); end
    z_issue_src_a = 14;
    #1;
    n_tests++; if (z_issue_ready !== 1'b1) begin n_fail++; $display("FAIL z_invalid_ready: got %b want 1", z_issue_ready); end
    @(negedge clk);
    n_tests++; if (z_busy !== 12'h020 || z_pending_count !== 4'd1)
      begin n_fail++; $display("FAIL z_invalid_issue: busy %h cnt %0d want 020/1", z_busy, z_pending_count); end
    idle_inputs();
  endtask

  task automatic test_random();
    bit iv, wv;
    int rd, sa, sb, wr;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      iv = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 2) != 0);
      rd = $urandom_range(0, 7);
      sa = $urandom_range(0, 15);
      sb = $urandom_range(0, 7);
      wr = $urandom_range(0, 7);
      cycle(iv, rd, sa, sb, wv, wr);
      n_tests++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, obs_ready, exp_ready); end
      n_tests++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy, exp_busy()); end
      n_tests++; if (reg_enable !== exp_en()) begin n_fail++; $display("FAIL rnd_en[%0d]: got %h want %h", n, reg_enable, exp_en()); end
      n_tests++; if (int'(pending_count) != exp_count()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, pending_count, exp_count()); end
      n_tests++; if (wb_error !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", n, wb_error, m_err); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_wb_not_busy();
    test_raw();
    test_same_edge();
    test_back_to_back_and_async_reset();
    test_zero_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
